// File: rtl/skew_feeder.sv
// skew_feeder: left-edge input stager for the weight-stationary systolic array.
// Accepts one column beat per handshake and delays lane r by r cycles so each
// PE row sees its operand aligned with the partial sums coming from above.
// After the final beat of a matrix it drains the skew chains, then pulses done.
module skew_feeder #(
  parameter int NUM_BITS = 8,
  parameter int ROWS     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [ROWS*NUM_BITS-1:0] in_data_i,
  input  logic                     in_last_i,
  output logic [ROWS*NUM_BITS-1:0] left_o,
  output logic [ROWS-1:0]          valid_o,
  output logic                     active_o,
  output logic                     done_o
);

  localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] drain_cnt;
  logic          hs;

  assign hs = in_valid_i && in_ready_o;

  // Sequencing FSM: ready and done are registered so the controller sees clean edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      in_ready_o <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          in_ready_o <= 1'b1;
          if (hs) begin
            if (in_last_i) begin
              if (ROWS > 1) begin
                state      <= DRAIN;
                drain_cnt  <= CW'(ROWS - 1);
                in_ready_o <= 1'b0;
              end else begin
                state  <= IDLE;
                done_o <= 1'b1;
              end
            end else begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - CW'(1);
          if (drain_cnt == CW'(1)) begin
            state      <= IDLE;
            done_o     <= 1'b1;
            in_ready_o <= 1'b1;
          end else begin
            in_ready_o <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          in_ready_o <= 1'b1;
        end
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [NUM_BITS-1:0] data_q [r+1];
    logic                tag_q  [r+1];

    // Free-running skew chain of r+1 stages; non-handshake cycles inject a zero bubble.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int j = 0; j <= r; j++) begin
          data_q[j] <= '0;
          tag_q[j]  <= 1'b0;
        end
      end else begin
        data_q[0] <= hs ? in_data_i[r*NUM_BITS +: NUM_BITS] : '0;
        tag_q[0]  <= hs;
        for (int j = 1; j <= r; j++) begin
          data_q[j] <= data_q[j-1];
          tag_q[j]  <= tag_q[j-1];
        end
      end
    end

    assign left_o[r*NUM_BITS +: NUM_BITS] = data_q[r];
    assign valid_o[r]                     = tag_q[r];
  end

  assign active_o = |valid_o;

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: scenario tasks plus a timeline model of accepted beats.
// The model records which edge accepted which beat and derives every output
// from the latency rules (lane r shows the beat from r edges earlier, etc).
module tb_skew_feeder;
  localparam int NB   = 8;
  localparam int ROWS = 4;
  localparam int W    = NB * ROWS;
  localparam int MAXE = 4096;

  logic          clk;
  logic          rst_ni;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [W-1:0]  left;
  logic [ROWS-1:0] valid;
  logic          active;
  logic          done;

  int n_cmp;
  int n_bad;

  bit           acc_v [MAXE];
  bit           acc_l [MAXE];
  logic [W-1:0] acc_d [MAXE];
  int           edge_n;

  skew_feeder #(.NUM_BITS(NB), .ROWS(ROWS)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .left_o(left), .valid_o(valid),
    .active_o(active), .done_o(done)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < MAXE; i++) begin
      acc_v[i] = 1'b0;
      acc_l[i] = 1'b0;
      acc_d[i] = '0;
    end
    edge_n = -1;
  endtask

  // Ready is low for the ROWS-1 cycles after a last beat, and before the first edge.
  function automatic logic exp_ready();
    if (edge_n < 0) return 1'b0;
    for (int k = edge_n - (ROWS - 2); k <= edge_n; k++)
      if (k >= 0 && acc_v[k] && acc_l[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_done();
    int k;
    k = edge_n - (ROWS - 1);
    return (k >= 0 && acc_v[k] && acc_l[k]);
  endfunction

  function automatic logic [W-1:0] exp_left();
    logic [W-1:0] res;
    int k;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      k = edge_n - r;
      if (k >= 0 && acc_v[k]) res[r*NB +: NB] = acc_d[k][r*NB +: NB];
    end
    return res;
  endfunction

  function automatic logic [ROWS-1:0] exp_valid();
    logic [ROWS-1:0] res;
    int k;
    res = '0;
    for (int r = 0; r < ROWS; r++) begin
      k = edge_n - r;
      if (k >= 0 && acc_v[k]) res[r] = 1'b1;
    end
    return res;
  endfunction

  // Advance one clock: decide acceptance from the model, log it, return at negedge.
  task automatic tick(output bit hs);
    hs = in_valid && exp_ready();
    @(posedge clk);
    if (edge_n < MAXE - 1) edge_n++;
    acc_v[edge_n] = hs;
    acc_l[edge_n] = in_last;
    acc_d[edge_n] = in_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit hs;
    rst_ni = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      in_last  = 1'($urandom);
      in_data  = $urandom;
      @(negedge clk);
      n_cmp++;
      if ({left, valid, active, done, in_ready} !== '0) begin
        n_bad++;
        $display("[TB] FAIL reset_hold outputs got %h/%b/%b/%b/%b want all zero",
                 left, valid, active, done, in_ready);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    model_reset();
    rst_ni = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_release_ready got %b want 0", in_ready);
    end
    tick(hs);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_first_edge_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    bit hs;
    int done_at;
    int low_cnt;
    done_at = -1;
    low_cnt = 0;
    in_data  = 32'h04030201;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(hs);
      in_valid = 1'b0;
      in_last  = 1'b0;
      n_cmp += 4;
      if (left !== exp_left()) begin
        n_bad++; $display("[TB] FAIL single_left step %0d got %h want %h", i, left, exp_left());
      end
      if (valid !== exp_valid()) begin
        n_bad++; $display("[TB] FAIL single_valid step %0d got %b want %b", i, valid, exp_valid());
      end
      if (done !== exp_done()) begin
        n_bad++; $display("[TB] FAIL single_done step %0d got %b want %b", i, done, exp_done());
      end
      if (in_ready !== exp_ready()) begin
        n_bad++; $display("[TB] FAIL single_ready step %0d got %b want %b", i, in_ready, exp_ready());
      end
      if (i < ROWS) begin
        n_cmp++;
        if (valid !== 4'(1 << i) || left[i*NB +: NB] !== 8'(i + 1)) begin
          n_bad++;
          $display("[TB] FAIL single_lane%0d got tag %b data %h want tag %b data %h",
                   i, valid, left[i*NB +: NB], 4'(1 << i), 8'(i + 1));
        end
      end
      if (done === 1'b1 && done_at < 0) done_at = i;
      if (in_ready === 1'b0) low_cnt++;
    end
    n_cmp += 2;
    if (done_at !== 3) begin
      n_bad++; $display("[TB] FAIL single_done_time got %0d want 3", done_at);
    end
    if (low_cnt !== 3) begin
      n_bad++; $display("[TB] FAIL single_ready_low_cycles got %0d want 3", low_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit hs;
    int act_cnt;
    int done_cnt;
    act_cnt  = 0;
    done_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      if (i < 4) begin
        in_valid = 1'b1;
        in_data  = {24'($urandom), 8'(8'h10 + i)};
        in_last  = (i == 3);
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      tick(hs);
      n_cmp += 5;
      if (left !== exp_left()) begin
        n_bad++; $display("[TB] FAIL b2b_left step %0d got %h want %h", i, left, exp_left());
      end
      if (valid !== exp_valid()) begin
        n_bad++; $display("[TB] FAIL b2b_valid step %0d got %b want %b", i, valid, exp_valid());
      end
      if (active !== (|exp_valid())) begin
        n_bad++; $display("[TB] FAIL b2b_active step %0d got %b want %b", i, active, |exp_valid());
      end
      if (done !== exp_done()) begin
        n_bad++; $display("[TB] FAIL b2b_done step %0d got %b want %b", i, done, exp_done());
      end
      if (in_ready !== exp_ready()) begin
        n_bad++; $display("[TB] FAIL b2b_ready step %0d got %b want %b", i, in_ready, exp_ready());
      end
      if (i < 4) begin
        n_cmp++;
        if (left[NB-1:0] !== 8'(8'h10 + i)) begin
          n_bad++; $display("[TB] FAIL b2b_lane0 step %0d got %h want %h", i, left[NB-1:0], 8'(8'h10 + i));
        end
      end
      if (active === 1'b1) act_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    n_cmp += 2;
    if (act_cnt !== 7) begin
      n_bad++; $display("[TB] FAIL b2b_active_cycles got %0d want 7", act_cnt);
    end
    if (done_cnt !== 1) begin
      n_bad++; $display("[TB] FAIL b2b_done_count got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_bubble();
    bit hs;
    logic [ROWS-1:0] tag_h [8];
    logic [W-1:0]    dat_h [8];
    int done_at;
    done_at = -1;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i == 0 || i == 2);
      in_last  = (i == 2);
      in_data  = $urandom | 32'h01010101;
      tick(hs);
      tag_h[i] = valid;
      dat_h[i] = left;
      n_cmp += 3;
      if (left !== exp_left()) begin
        n_bad++; $display("[TB] FAIL bubble_left step %0d got %h want %h", i, left, exp_left());
      end
      if (valid !== exp_valid()) begin
        n_bad++; $display("[TB] FAIL bubble_valid step %0d got %b want %b", i, valid, exp_valid());
      end
      if (done !== exp_done()) begin
        n_bad++; $display("[TB] FAIL bubble_done step %0d got %b want %b", i, done, exp_done());
      end
      if (done === 1'b1 && done_at < 0) done_at = i;
    end
    for (int r = 0; r < ROWS; r++) begin
      n_cmp++;
      if ({tag_h[r][r], tag_h[r+1][r], tag_h[r+2][r]} !== 3'b101 || dat_h[r+1][r*NB +: NB] !== '0) begin
        n_bad++;
        $display("[TB] FAIL bubble_lane%0d got tags %b%b%b gap %h want 101 gap 00", r,
                 tag_h[r][r], tag_h[r+1][r], tag_h[r+2][r], dat_h[r+1][r*NB +: NB]);
      end
    end
    n_cmp++;
    if (done_at - 2 !== 3) begin
      n_bad++; $display("[TB] FAIL bubble_done_delay got %0d want 3", done_at - 2);
    end
  endtask

  task automatic test_backpressure();
    bit hs;
    int done_at;
    int lane0_at;
    logic [W-1:0] held;
    done_at  = -1;
    lane0_at = -1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = $urandom;
    tick(hs);
    held    = $urandom;
    in_data = held;
    for (int i = 1; i < 10; i++) begin
      tick(hs);
      if (hs) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      n_cmp += 3;
      if (left !== exp_left()) begin
        n_bad++; $display("[TB] FAIL bp_left step %0d got %h want %h", i, left, exp_left());
      end
      if (done !== exp_done()) begin
        n_bad++; $display("[TB] FAIL bp_done step %0d got %b want %b", i, done, exp_done());
      end
      if (in_ready !== exp_ready()) begin
        n_bad++; $display("[TB] FAIL bp_ready step %0d got %b want %b", i, in_ready, exp_ready());
      end
      if (done === 1'b1 && done_at < 0) done_at = i;
      if (valid[0] === 1'b1 && lane0_at < 0) begin
        lane0_at = i;
        n_cmp++;
        if (left[NB-1:0] !== held[NB-1:0]) begin
          n_bad++; $display("[TB] FAIL bp_lane0_data got %h want %h", left[NB-1:0], held[NB-1:0]);
        end
      end
    end
    n_cmp += 2;
    if (done_at !== 3) begin
      n_bad++; $display("[TB] FAIL bp_done_time got %0d want 3", done_at);
    end
    if (lane0_at !== 4) begin
      n_bad++; $display("[TB] FAIL bp_lane0_time got %0d want 4", lane0_at);
    end
  endtask

  task automatic test_reset_mid_drain();
    bit hs;
    int done_cnt;
    done_cnt = 0;
    in_valid = 1'b1;
    in_last  = 1'b1;
    in_data  = $urandom;
    tick(hs);
    in_valid = 1'b0;
    in_last  = 1'b0;
    tick(hs);
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({left, valid, active, done, in_ready} !== '0) begin
      n_bad++;
      $display("[TB] FAIL mid_reset_immediate got %h/%b/%b/%b/%b want all zero",
               left, valid, active, done, in_ready);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(hs);
      n_cmp += 3;
      if (done !== exp_done()) begin
        n_bad++; $display("[TB] FAIL mid_reset_done step %0d got %b want %b", i, done, exp_done());
      end
      if (valid !== exp_valid()) begin
        n_bad++; $display("[TB] FAIL mid_reset_valid step %0d got %b want %b", i, valid, exp_valid());
      end
      if (in_ready !== exp_ready()) begin
        n_bad++; $display("[TB] FAIL mid_reset_ready step %0d got %b want %b", i, in_ready, exp_ready());
      end
      if (done === 1'b1) done_cnt++;
    end
    n_cmp++;
    if (done_cnt !== 0) begin
      n_bad++; $display("[TB] FAIL mid_reset_no_done got %0d want 0", done_cnt);
    end
  endtask

  task automatic test_random();
    bit hs;
    hs = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !hs)) begin
        in_valid = (i < 390) && ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        in_last  = ($urandom_range(0, 5) == 0);
      end
      tick(hs);
      n_cmp += 5;
      if (left !== exp_left()) begin
        n_bad++; $display("[TB] FAIL rand_left step %0d got %h want %h", i, left, exp_left());
      end
      if (valid !== exp_valid()) begin
        n_bad++; $display("[TB] FAIL rand_valid step %0d got %b want %b", i, valid, exp_valid());
      end
      if (active !== (|exp_valid())) begin
        n_bad++; $display("[TB] FAIL rand_active step %0d got %b want %b", i, active, |exp_valid());
      end
      if (done !== exp_done()) begin
        n_bad++; $display("[TB] FAIL rand_done step %0d got %b want %b", i, done, exp_done());
      end
      if (in_ready !== exp_ready()) begin
        n_bad++; $display("[TB] FAIL rand_ready step %0d got %b want %b", i, in_ready, exp_ready());
      end
    end
  endtask

  // Scenario sequence
  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_ni   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_bubble();
    test_backpressure();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/skew_feeder.md
# skew_feeder

Left-edge input stager for the weight-stationary systolic array. It accepts one B-column beat per handshake, one element per array row. It then delays row r by r cycles so that each PE row's `left_i` receives its operand aligned with the partial sums arriving from above. After the final beat of a matrix it flushes the skew pipeline and signals completion to the array controller.

## Interface
Parameters:
- `NUM_BITS`, default `pkg::NUM_BITS`: element width; matches the PE datapath.
- `ROWS`, default 4: number of array rows (lanes), ≥1.

Ports:
- `clk_i`, input, 1: single clock, rising edge.
- `rst_ni`, input, 1: asynchronous active-low reset.
- `in_valid_i`, input, 1: beat valid.
- `in_ready_o`, output, 1: beat accepted when `in_valid_i && in_ready_o` at a rising edge.
- `in_data_i`, input, ROWS*NUM_BITS: lane r is `[r*NUM_BITS +: NUM_BITS]`.
- `in_last_i`, input, 1: final beat of the matrix; qualified by the handshake.
- `left_o`, output, ROWS*NUM_BITS: per-row operands to the PE `left_i` edge, same packing as `in_data_i`.
- `valid_o`, output, ROWS: per-lane tag; 1 means real data, 0 means bubble.
- `active_o`, output, 1: OR of `valid_o`.
- `done_o`, output, 1: one-cycle pulse when the last element has reached lane ROWS-1.

## Operation
- Lane r is a chain of r+1 registers for data and tag. Lane 0 is a single output register.
- All lanes shift every cycle, unconditionally. The array runs free, so every lane keeps relative alignment.
- Handshake cycle: each lane's chain input takes `in_data_i` lane r with tag 1.
- Non-handshake cycle: each lane's chain input takes zero with tag 0. Bubbles are always zero data.
- FSM states: IDLE, STREAM, DRAIN. `in_ready_o` is 1 in IDLE and STREAM and 0 in DRAIN.
  - IDLE, handshake with `in_last_i`=0: go to STREAM.
  - IDLE or STREAM, handshake with `in_last_i`=1, ROWS>1: go to DRAIN and load the drain counter with ROWS-1.
  - IDLE or STREAM, handshake with `in_last_i`=1, ROWS==1: stay in or go to IDLE and set `done_o`.
  - STREAM, no handshake: stay in STREAM and insert a bubble. `in_last_i` is ignored without `in_valid_i`.
  - DRAIN: decrement the counter every cycle. At an edge with counter==1, go to IDLE and set `done_o` for exactly one cycle.
- Drain counter width is `$clog2(ROWS)` (minimum 1).
- Source rule: while `in_valid_i && !in_ready_o`, the source holds `in_data_i` and `in_last_i` stable. A beat presented during DRAIN is accepted on the first IDLE cycle.
- Reset values:
  - `left_o` = 0, `valid_o` = 0, `active_o` = 0, `done_o` = 0.
  - State is IDLE, counter is 0.
  - `in_ready_o` is a register with reset value 0. It goes to 1 at the first edge after `rst_ni` rises.
- Reset mid-operation (any state) clears all chains and the FSM immediately. No `done_o` is produced for the aborted matrix.

## Timing
- Beat accepted at edge k: lane r data and tag appear on `left_o` / `valid_o` after edge k+r. Lane 0 latency is one cycle; lane ROWS-1 latency is ROWS cycles.
- Last beat at edge k (ROWS>1):
  - DRAIN occupies the ROWS-1 cycles following edge k, with `in_ready_o` low.
  - The FSM returns to IDLE after edge k+ROWS-1.
  - `done_o` is high in the cycle after edge k+ROWS-1, coincident with the last element on lane ROWS-1.
- Last beat at edge k (ROWS==1): `done_o` is high in the cycle after edge k, and `in_ready_o` stays 1.
- Back-to-back matrices: the next matrix's first beat is accepted no earlier than the cycle `done_o` is high.
- `active_o` is combinational from the tag registers; all other outputs come straight from registers.

## Test plan
All scenarios use ROWS=4, NUM_BITS=8.
- **Reset:** hold `rst_ni`=0 with random inputs. Required: all outputs 0. After release, `in_ready_o`=1 one edge later.
- **Single beat:** `in_data_i`=0x04030201 with `in_last_i`=1, accepted at edge k.
  - Lane 0 = 0x01 after k, lane 1 = 0x02 after k+1, lane 2 = 0x03 after k+2, lane 3 = 0x04 after k+3, each with tag 1 for one cycle only.
  - `in_ready_o` low for 3 cycles; `done_o` high after k+3.
- **Four back-to-back beats** 0x..10 through 0x..13 (lane 0 bytes), last on the 4th beat. Required:
  - Lane 0 shows 0x10–0x13 over consecutive cycles.
  - `active_o` is high continuously for 7 cycles.
  - `done_o` fires once.
- **Bubble:** beat, one idle cycle, then beat with last. Required:
  - Every lane shows value, zero with tag 0, value at its own r-cycle offset.
  - `done_o` fires 3 cycles after the last handshake.
- **Backpressure:** hold `in_valid_i`=1 with a new beat during DRAIN. Required: not accepted until the IDLE cycle in which `done_o`=1; that beat's lane 0 appears one cycle later.
- **Reset mid-DRAIN:** assert `rst_ni`=0 one cycle after the last beat. Required: all outputs 0 immediately, no `done_o` pulse, and normal operation after release.
